// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift pipeline and its barrel shifter.
//   - 3-bit opcode encodings for the shift operations
//   - is_legal_opr(): flags the two unassigned opcode points (011, 111)
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam logic [2:0] OPR_LSR = 3'b000;
  localparam logic [2:0] OPR_ASR = 3'b001;
  localparam logic [2:0] OPR_ROR = 3'b010;
  localparam logic [2:0] OPR_LSL = 3'b100;
  localparam logic [2:0] OPR_ASL = 3'b101;
  localparam logic [2:0] OPR_ROL = 3'b110;

  // Returns 1 for every opcode that has a defined meaning.
  function automatic logic is_legal_opr(input logic [2:0] opr);
    logic legal;
    case (opr)
      OPR_LSR, OPR_ASR, OPR_ROR,
      OPR_LSL, OPR_ASL, OPR_ROL: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// -----------------------------------------------------------------------------
// barrel_shifter
// Purely combinational shifter/rotator.
// Ports:
//   data_i    DATA_WIDTH   operand
//   amount_i  SHIFT_WIDTH  shift amount (0 .. DATA_WIDTH-1)
//   opr_i     3            opcode (see shift_pkg); undefined codes act as LSR
//   data_o    DATA_WIDTH   shifted / rotated result
// -----------------------------------------------------------------------------
module barrel_shifter
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHIFT_WIDTH-1:0] amount_i,
  input  logic [2:0]             opr_i,
  output logic [DATA_WIDTH-1:0]  data_o
);

  logic signed [DATA_WIDTH-1:0] dataSigned;
  int unsigned                  backAmount;

  assign dataSigned = $signed(data_i);

  // Rotations are built from two opposing shifts. For a zero amount the
  // complementary shift is by the full width, which yields zero, so the
  // OR leaves the operand unchanged.
  assign backAmount = DATA_WIDTH - int'(amount_i);

  // Select the result for the requested operation; the default arm covers
  // LSR as well as the two undefined opcodes, which execute as LSR.
  always_comb begin
    data_o = data_i >> amount_i;
    case (opr_i)
      OPR_ASR:          data_o = dataSigned >>> amount_i;
      OPR_ROR:          data_o = (data_i >> amount_i) | (data_i << backAmount);
      OPR_LSL, OPR_ASL: data_o = data_i << amount_i;
      OPR_ROL:          data_o = (data_i << amount_i) | (data_i >> backAmount);
      default:          data_o = data_i >> amount_i;
    endcase
  end

endmodule

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
// Two-stage registered, valid/ready wrapper around barrel_shifter.
//   S1 captures the command operands, S2 captures the shifter result and the
//   status flags. Bubbles collapse, and an accept and an emit may happen in the
//   same cycle.
// Ports:
//   CLK       in   1            clock, rising edge
//   RST       in   1            asynchronous active-high reset
//   IVALID    in   1            command valid
//   IREADY    out  1            command accepted when IVALID && IREADY
//   IDATA     in   DATA_WIDTH   operand
//   N_SHIFT   in   SHIFT_WIDTH  shift amount
//   OPR       in   3            opcode
//   OVALID    out  1            result valid
//   OREADY    in   1            result consumed when OVALID && OREADY
//   ODATA     out  DATA_WIDTH   shifted result
//   OZERO     out  1            ODATA == 0
//   OCARRY    out  1            last bit shifted out (0 for rotates / N = 0)
//   OERR      out  1            opcode was undefined
//   OP_COUNT  out  CNT_WIDTH    completed output transfers (wrapping)
// -----------------------------------------------------------------------------
module shift_pipe
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IVALID,
  output logic                   IREADY,
  input  logic [DATA_WIDTH-1:0]  IDATA,
  input  logic [SHIFT_WIDTH-1:0] N_SHIFT,
  input  logic [2:0]             OPR,
  output logic                   OVALID,
  input  logic                   OREADY,
  output logic [DATA_WIDTH-1:0]  ODATA,
  output logic                   OZERO,
  output logic                   OCARRY,
  output logic                   OERR,
  output logic [CNT_WIDTH-1:0]   OP_COUNT
);

  // Stage 1 state
  logic                   s1Valid_q, s1Valid_d;
  logic [DATA_WIDTH-1:0]  s1Data_q,  s1Data_d;
  logic [SHIFT_WIDTH-1:0] s1Shift_q, s1Shift_d;
  logic [2:0]             s1Opr_q,   s1Opr_d;

  // Stage 2 state
  logic                   s2Valid_q, s2Valid_d;
  logic [DATA_WIDTH-1:0]  s2Data_q,  s2Data_d;
  logic                   s2Zero_q,  s2Zero_d;
  logic                   s2Carry_q, s2Carry_d;
  logic                   s2Err_q,   s2Err_d;

  logic [CNT_WIDTH-1:0]   opCount_q, opCount_d;

  logic                   s1Adv;
  logic                   s2Adv;
  logic [DATA_WIDTH-1:0]  shiftResult;
  logic                   carryBit;
  logic [SHIFT_WIDTH-1:0] lslCarryIdx;
  logic [SHIFT_WIDTH-1:0] lsrCarryIdx;

  // A stage advances when it is empty or its downstream can take its data.
  assign s2Adv  = !s2Valid_q || OREADY;
  assign s1Adv  = !s1Valid_q || s2Adv;
  assign IREADY = s1Adv;

  barrel_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_shifter (
    .data_i   (s1Data_q),
    .amount_i (s1Shift_q),
    .opr_i    (s1Opr_q),
    .data_o   (shiftResult)
  );

  // The left-shift carry comes from bit DATA_WIDTH-N. Because DATA_WIDTH is a
  // power of two, that index is simply -N modulo the shift-amount width.
  assign lslCarryIdx = '0 - s1Shift_q;
  assign lsrCarryIdx = s1Shift_q - SHIFT_WIDTH'(1);

  // Carry-out is the last bit pushed off the end; rotates lose no bits and a
  // zero shift pushes nothing out, so both report 0.
  always_comb begin
    carryBit = 1'b0;
    if (s1Shift_q != '0) begin
      case (s1Opr_q)
        OPR_ROR, OPR_ROL: carryBit = 1'b0;
        OPR_LSL, OPR_ASL: carryBit = s1Data_q[lslCarryIdx];
        default:          carryBit = s1Data_q[lsrCarryIdx];
      endcase
    end
  end

  // Stage 1 next state: take a new command whenever the stage advances;
  // operand registers only change when a command is actually accepted.
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Data_d  = s1Data_q;
    s1Shift_d = s1Shift_q;
    s1Opr_d   = s1Opr_q;
    if (s1Adv) begin
      s1Valid_d = IVALID;
      if (IVALID) begin
        s1Data_d  = IDATA;
        s1Shift_d = N_SHIFT;
        s1Opr_d   = OPR;
      end
    end
  end

  // Stage 2 next state: result and flags are captured together so that
  // everything presented with OVALID belongs to the same command and holds
  // steady while the consumer stalls.
  always_comb begin
    s2Valid_d = s2Valid_q;
    s2Data_d  = s2Data_q;
    s2Zero_d  = s2Zero_q;
    s2Carry_d = s2Carry_q;
    s2Err_d   = s2Err_q;
    if (s2Adv) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Data_d  = shiftResult;
        s2Zero_d  = (shiftResult == '0);
        s2Carry_d = carryBit;
        s2Err_d   = !is_legal_opr(s1Opr_q);
      end
    end
  end

  // Completed-transfer counter; wraps naturally at all-ones.
  always_comb begin
    opCount_d = opCount_q;
    if (s2Valid_q && OREADY) begin
      opCount_d = opCount_q + CNT_WIDTH'(1);
    end
  end

  // All pipeline state; reset discards any in-flight commands immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s1Shift_q <= '0;
      s1Opr_q   <= '0;
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
      s2Zero_q  <= 1'b0;
      s2Carry_q <= 1'b0;
      s2Err_q   <= 1'b0;
      opCount_q <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Data_q  <= s1Data_d;
      s1Shift_q <= s1Shift_d;
      s1Opr_q   <= s1Opr_d;
      s2Valid_q <= s2Valid_d;
      s2Data_q  <= s2Data_d;
      s2Zero_q  <= s2Zero_d;
      s2Carry_q <= s2Carry_d;
      s2Err_q   <= s2Err_d;
      opCount_q <= opCount_d;
    end
  end

  assign OVALID   = s2Valid_q;
  assign ODATA    = s2Data_q;
  assign OZERO    = s2Zero_q;
  assign OCARRY   = s2Carry_q;
  assign OERR     = s2Err_q;
  assign OP_COUNT = opCount_q;

endmodule
